alu_issue: RTL and testbench

Issue/writeback sequencer directly upstream of the ALU. It owns an 8×16-bit register file, accepts one instruction at a time over a valid/ready handshake, and reads operands. It drives the ALU's `bgn`/`opcode`/`A`/`B` start handshake, waits for `rdy`, then writes `acc1`/`acc2` back and latches the four status flags. A cycle-count watchdog recovers from an ALU that never answers.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_regfile.sv | 44 ++++
 rtl/alu_issue.sv | 190 +++++++++++++++++++
 tb/tb_alu_issue.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_ADC = 5'd2;
    localparam logic [4:0] OP_SUB = 5'd3;
    localparam logic [4:0] OP_SBC = 5'd4;
    localparam logic [4:0] OP_MUL = 5'd5;
    localparam logic [4:0] OP_DIV = 5'd6;
    localparam logic [4:0] OP_AND = 5'd7;
    localparam logic [4:0] OP_OR  = 5'd8;
    localparam logic [4:0] OP_XOR = 5'd9;
    localparam logic [4:0] OP_NOT = 5'd10;
    localparam logic [4:0] OP_SHL = 5'd11;
    localparam logic [4:0] OP_SHR = 5'd12;
    localparam logic [4:0] OP_ROL = 5'd13;
    localparam logic [4:0] OP_ROR = 5'd14;
    localparam logic [4:0] OP_CMP = 5'd15;
    localparam logic [4:0] OP_TST = 5'd16;
    localparam logic [4:0] OP_INC = 5'd17;
    localparam logic [4:0] OP_DEC = 5'd18;
    localparam logic [4:0] OP_NOP = 5'd31;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB,
        RETIRE
    } state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_legal(input logic [4:0] op);
        return ((op >= OP_ADD) && (op <= OP_DEC)) || (op == OP_NOP);
    endfunction

    // Ops that return a double-width result in acc1/acc2.
    function automatic logic is_pair_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Ops that only update flags and never write a register.
    function automatic logic is_flag_only(input logic [4:0] op);
        return (op == OP_CMP) || (op == OP_TST);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x 16-bit register file: two write ports, three combinational read ports.
module alu_regfile #(
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic [15:0]   wd0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [15:0]   wd1,
    input  logic [AW-1:0] ra_a,
    output logic [15:0]   rd_a,
    input  logic [AW-1:0] ra_b,
    output logic [15:0]   rd_b,
    input  logic [AW-1:0] ra_dbg,
    output logic [15:0]   rd_dbg
);

    logic [15:0] mem [NREG];

    // Storage; port 0 is written last so it wins on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we1) begin
                mem[wa1] <= wd1;
            end
            if (we0) begin
                mem[wa0] <= wd0;
            end
        end
    end

    assign rd_a   = mem[ra_a];
    assign rd_b   = mem[ra_b];
    assign rd_dbg = mem[ra_dbg];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback sequencer in front of the ALU, with a WAIT-state watchdog.
module alu_issue
    import alu_pkg::*;
#(
    parameter int NREG    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [4:0]               instr_op,
    input  logic [$clog2(NREG)-1:0]  instr_rd,
    input  logic [$clog2(NREG)-1:0]  instr_rs,
    input  logic                     instr_imm_en,
    input  logic [15:0]              instr_imm,
    output logic                     alu_bgn,
    output logic [5:0]               alu_opcode,
    output logic [15:0]              alu_a,
    output logic [15:0]              alu_b,
    input  logic [15:0]              alu_acc1,
    input  logic [15:0]              alu_acc2,
    input  logic                     alu_zero,
    input  logic                     alu_negative,
    input  logic                     alu_carry,
    input  logic                     alu_overflow,
    input  logic                     alu_rdy,
    output logic [3:0]               flags,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [15:0]              dbg_data
);

    localparam int AW  = $clog2(NREG);
    localparam int WDW = $clog2(TIMEOUT + 1);

    state_t         state, state_nxt;
    logic [4:0]     op_q;
    logic [AW-1:0]  rd_q;
    logic [AW-1:0]  rd_pair;
    logic [15:0]    a_q, b_q, acc1_q, acc2_q;
    logic [15:0]    rf_a, rf_b;
    logic [3:0]     fl_in, fl_q;
    logic [WDW-1:0] wd_cnt;
    logic           accept;
    logic           we0, we1, flags_ld, cap, err_set, wd_clr, wd_inc;

    assign accept      = (state == IDLE) && instr_valid;
    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = (state == RETIRE);
    assign alu_bgn     = (state == ISSUE);
    assign alu_opcode  = {1'b0, op_q};
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rd_pair     = (rd_q == AW'(NREG - 1)) ? '0 : rd_q + 1'b1;

    // Pack the ALU flag inputs into the {Z,N,C,V} layout.
    always_comb begin
        fl_in         = '0;
        fl_in[FLAG_Z] = alu_zero;
        fl_in[FLAG_N] = alu_negative;
        fl_in[FLAG_C] = alu_carry;
        fl_in[FLAG_V] = alu_overflow;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes; alu_rdy is only trusted in WAIT.
    always_comb begin
        state_nxt = state;
        we0       = 1'b0;
        we1       = 1'b0;
        flags_ld  = 1'b0;
        cap       = 1'b0;
        err_set   = 1'b0;
        wd_clr    = 1'b0;
        wd_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (instr_op == OP_NOP) begin
                        state_nxt = RETIRE;
                    end else if (!is_legal(instr_op)) begin
                        err_set   = 1'b1;
                        state_nxt = RETIRE;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                wd_clr    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (alu_rdy) begin
                    cap       = 1'b1;
                    state_nxt = WB;
                end else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            WB: begin
                flags_ld  = 1'b1;
                we0       = !is_flag_only(op_q);
                we1       = is_pair_op(op_q);
                state_nxt = RETIRE;
            end
            RETIRE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand/result latches, flags, sticky error and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            rd_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc1_q <= '0;
            acc2_q <= '0;
            fl_q   <= '0;
            flags  <= '0;
            err    <= 1'b0;
            wd_cnt <= '0;
        end else begin
            if (accept) begin
                op_q <= instr_op;
                rd_q <= instr_rd;
                a_q  <= rf_a;
                b_q  <= instr_imm_en ? instr_imm : rf_b;
            end
            if (cap) begin
                acc1_q <= alu_acc1;
                acc2_q <= alu_acc2;
                fl_q   <= fl_in;
            end
            if (flags_ld) begin
                flags <= fl_q;
            end
            if (err_set) begin
                err <= 1'b1;
            end
            if (wd_clr) begin
                wd_cnt <= '0;
            end else if (wd_inc) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    alu_regfile #(
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we0    (we0),
        .wa0    (rd_q),
        .wd0    (acc1_q),
        .we1    (we1),
        .wa1    (rd_pair),
        .wd1    (acc2_q),
        .ra_a   (instr_rd),
        .rd_a   (rf_a),
        .ra_b   (instr_rs),
        .rd_b   (rf_b),
        .ra_dbg (dbg_addr),
        .rd_dbg (dbg_data)
    );

endmodule

// File: tb/tb_alu_issue.sv
`timescale 1ns/1ps
module tb_alu_issue;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, instr_ready;
    logic [4:0]  instr_op;
    logic [2:0]  instr_rd, instr_rs;
    logic        instr_imm_en;
    logic [15:0] instr_imm;
    logic        alu_bgn;
    logic [5:0]  alu_opcode;
    logic [15:0] alu_a, alu_b, alu_acc1, alu_acc2;
    logic        alu_zero, alu_negative, alu_carry, alu_overflow, alu_rdy;
    logic [3:0]  flags;
    logic        busy, done, err;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    alu_issue #(.NREG(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
        .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
        .alu_bgn(alu_bgn), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_acc1(alu_acc1), .alu_acc2(alu_acc2),
        .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_rdy(alu_rdy),
        .flags(flags), .busy(busy), .done(done), .err(err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [2:0]  a0;
        logic [15:0] d0;
        logic [2:0]  a1;
        logic [15:0] d1;
        logic [3:0]  fl;
        logic        er;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // ALU model controls
    logic        m_hang;
    logic [15:0] m_acc1, m_acc2;
    logic [3:0]  m_fl;
    int          bgn_cnt = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_retire(input logic [2:0] a0, input logic [15:0] d0,
                                 input logic [2:0] a1, input logic [15:0] d1,
                                 input logic [3:0] fl, input logic er);
        exp_t e;
        e.a0 = a0; e.d0 = d0; e.a1 = a1; e.d1 = d1; e.fl = fl; e.er = er;
        sbq.push_back(e);
    endtask

    // ALU model: answers one cycle after bgn, or stalls with a stale rdy.
    initial begin
        logic drop_next;
        drop_next = 1'b0;
        alu_rdy = 1'b0; alu_acc1 = '0; alu_acc2 = '0;
        {alu_zero, alu_negative, alu_carry, alu_overflow} = 4'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                drop_next = 1'b0;
                alu_rdy   = 1'b0;
            end else begin
                if (drop_next) begin
                    alu_rdy   = 1'b0;
                    drop_next = 1'b0;
                end
                if (alu_bgn) begin
                    bgn_cnt++;
                    if (m_hang) begin
                        alu_acc1 = 16'hDEAD;
                        alu_acc2 = 16'hBEEF;
                        {alu_zero, alu_negative, alu_carry, alu_overflow} = 4'hF;
                        drop_next = 1'b1;
                    end else begin
                        alu_acc1 = m_acc1;
                        alu_acc2 = m_acc2;
                        {alu_zero, alu_negative, alu_carry, alu_overflow} = m_fl;
                        alu_rdy  = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: register scan after each reset, scoreboard check on each done.
    initial begin
        logic scan_pending;
        exp_t e;
        scan_pending = 1'b1;
        dbg_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                scan_pending = 1'b1;
            end else begin
                if (scan_pending) begin
                    scan_pending = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        dbg_addr = 3'(i);
                        #1;
                        check("reset_reg", dbg_data, 16'h0);
                    end
                end
                if (done) begin
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done: got done=1 expected no retire (t=%0t)", $time);
                    end else begin
                        e = sbq.pop_front();
                        check("flags", 16'(flags), 16'(e.fl));
                        check("err", 16'(err), 16'(e.er));
                        dbg_addr = e.a0;
                        #1;
                        check("reg_a0", dbg_data, e.d0);
                        dbg_addr = e.a1;
                        #1;
                        check("reg_a1", dbg_data, e.d1);
                    end
                end
            end
        end
    end

    // lat: cycles from accept edge to done (4 issued, 1 NOP/illegal, 0 = expect timeout)
    task automatic send(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic ie, input logic [15:0] imm, input int lat,
                        input logic chk_ops, input logic [15:0] ea, input logic [15:0] eb);
        int   n;
        int   b0;
        logic seen;
        @(negedge clk);
        check("instr_ready", 16'(instr_ready), 16'd1);
        instr_op = op; instr_rd = rd; instr_rs = rs; instr_imm_en = ie; instr_imm = imm;
        instr_valid = 1'b1;
        b0 = bgn_cnt;
        seen = 1'b0;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        instr_imm = 16'hBAD0;
        instr_op  = OP_NOP;
        if (lat == 0) instr_valid = 1'b0;
        while (1) begin
            if (n == 1 && chk_ops) begin
                check("issue_bgn", 16'(alu_bgn), 16'd1);
                check("issue_a", alu_a, ea);
                check("issue_b", alu_b, eb);
                check("issue_opcode", 16'(alu_opcode), 16'(op));
            end
            if (lat == 0 && n == 65) check("busy_last_wait", 16'(busy), 16'd1);
            if (lat == 0 && n == 66) check("busy_after_abort", 16'(busy), 16'd0);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (n >= ((lat == 0) ? 70 : 10)) break;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        if (lat == 0) begin
            check("timeout_no_done", 16'(seen), 16'd0);
            check("timeout_err", 16'(err), 16'd1);
        end else begin
            check("done_latency", 16'(n), 16'(lat));
        end
        check("bgn_pulses", 16'(bgn_cnt - b0), (lat == 1) ? 16'd0 : 16'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs = '0;
        instr_imm_en = 1'b0; instr_imm = '0;
        m_hang = 1'b0; m_acc1 = '0; m_acc2 = '0; m_fl = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", 16'(instr_ready), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_err", 16'(err), 16'd0);
        check("rst_flags", 16'(flags), 16'd0);
        check("rst_bgn", 16'(alu_bgn), 16'd0);
        check("rst_opcode", 16'(alu_opcode), 16'd0);
        check("rst_a", alu_a, 16'd0);
        check("rst_b", alu_b, 16'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // ADD R1 += imm 5
        m_acc1 = 16'h0005; m_acc2 = 16'h0; m_fl = 4'b0000;
        expect_retire(3'd1, 16'h0005, 3'd0, 16'h0000, 4'b0000, 1'b0);
        send(OP_ADD, 3'd1, 3'd0, 1'b1, 16'h0005, 4, 1'b1, 16'h0000, 16'h0005);

        // ADD R2 += R1, B must reflect the previous writeback
        m_acc1 = 16'h0105; m_fl = 4'b0010;
        expect_retire(3'd2, 16'h0105, 3'd1, 16'h0005, 4'b0010, 1'b0);
        send(OP_ADD, 3'd2, 3'd1, 1'b0, 16'h0000, 4, 1'b1, 16'h0000, 16'h0005);

        // MUL on R7: pair write wraps into R0
        m_acc1 = 16'h1234; m_acc2 = 16'h00AB; m_fl = 4'b0100;
        expect_retire(3'd7, 16'h1234, 3'd0, 16'h00AB, 4'b0100, 1'b0);
        send(OP_MUL, 3'd7, 3'd2, 1'b0, 16'h0000, 4, 1'b1, 16'h0000, 16'h0105);

        // CMP: flags only
        m_acc1 = 16'hFFFF; m_acc2 = 16'h0; m_fl = 4'b1000;
        expect_retire(3'd7, 16'h1234, 3'd0, 16'h00AB, 4'b1000, 1'b0);
        send(OP_CMP, 3'd7, 3'd0, 1'b1, 16'h1234, 4, 1'b1, 16'h1234, 16'h1234);

        // Illegal opcode 21
        expect_retire(3'd3, 16'h0000, 3'd7, 16'h1234, 4'b1000, 1'b1);
        send(5'b10101, 3'd3, 3'd0, 1'b0, 16'h0000, 1, 1'b0, 16'h0, 16'h0);

        // Reset asserted in the middle of WAIT
        m_hang = 1'b1;
        @(negedge clk);
        instr_op = OP_INC; instr_rd = 3'd1; instr_rs = 3'd0; instr_imm_en = 1'b1;
        instr_imm = 16'h0001; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midwait_busy", 16'(busy), 16'd1);
        rst_n = 1'b0;
        #1;
        check("arst_ready", 16'(instr_ready), 16'd1);
        check("arst_busy", 16'(busy), 16'd0);
        check("arst_done", 16'(done), 16'd0);
        check("arst_err", 16'(err), 16'd0);
        check("arst_flags", 16'(flags), 16'd0);
        check("arst_bgn", 16'(alu_bgn), 16'd0);
        check("arst_opcode", 16'(alu_opcode), 16'd0);
        check("arst_a", alu_a, 16'd0);
        check("arst_b", alu_b, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_hang = 1'b0;
        repeat (3) @(negedge clk);

        // ADD R1 += 5 with V set; leaves a stale rdy high for the next op
        m_acc1 = 16'h0005; m_acc2 = 16'h0; m_fl = 4'b0001;
        expect_retire(3'd1, 16'h0005, 3'd0, 16'h0000, 4'b0001, 1'b0);
        send(OP_ADD, 3'd1, 3'd0, 1'b1, 16'h0005, 4, 1'b1, 16'h0000, 16'h0005);

        // SUB with an ALU that never answers: watchdog abort
        m_hang = 1'b1;
        send(OP_SUB, 3'd1, 3'd0, 1'b1, 16'h0001, 0, 1'b1, 16'h0005, 16'h0001);
        m_hang = 1'b0;

        // NOP: R1 and flags untouched by the aborted SUB
        expect_retire(3'd1, 16'h0005, 3'd0, 16'h0000, 4'b0001, 1'b1);
        send(OP_NOP, 3'd1, 3'd0, 1'b0, 16'h0000, 1, 1'b0, 16'h0, 16'h0);

        // DEC R4 accepted normally after the abort
        m_acc1 = 16'hFFFF; m_acc2 = 16'h0; m_fl = 4'b0100;
        expect_retire(3'd4, 16'hFFFF, 3'd1, 16'h0005, 4'b0100, 1'b1);
        send(OP_DEC, 3'd4, 3'd4, 1'b0, 16'h0000, 4, 1'b1, 16'h0000, 16'h0000);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 16'(sbq.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
